// File: rtl/dump_arbiter_if.sv
// Bundle of per-channel dump signals and the shared IPbus RAM/handshake port
// seen by dump_arbiter; the arbiter takes the slave view.
interface dump_arbiter_if #(
  parameter int CHW = 2
);
  localparam int NCH = 2**CHW;

  // dataChannel side
  logic [NCH-1:0]    req;
  logic [NCH*32-1:0] ch_ram_data;
  logic [NCH*8-1:0]  ch_ram_address;
  logic [NCH-1:0]    ch_ram_we;
  logic [NCH-1:0]    ch_handshakeFPGA;
  logic [NCH-1:0]    ch_handshakePC;
  logic [NCH-1:0]    grant;

  // IPbus side
  logic              handshakePC;
  logic [31:0]       IPbus_RAM_data;
  logic [7:0]        IPbus_RAM_address;
  logic              IPbus_RAM_we;
  logic              handshakeFPGA;

  // status
  logic [CHW-1:0]    active_ch;
  logic              busy;
  logic [15:0]       timeout_count;

  modport slave (
    input  req, ch_ram_data, ch_ram_address, ch_ram_we, ch_handshakeFPGA, handshakePC,
    output grant, ch_handshakePC, IPbus_RAM_data, IPbus_RAM_address, IPbus_RAM_we,
           handshakeFPGA, active_ch, busy, timeout_count
  );

  modport master (
    output req, ch_ram_data, ch_ram_address, ch_ram_we, ch_handshakeFPGA, handshakePC,
    input  grant, ch_handshakePC, IPbus_RAM_data, IPbus_RAM_address, IPbus_RAM_we,
           handshakeFPGA, active_ch, busy, timeout_count
  );
endinterface

// File: rtl/dump_arbiter.sv
// Round-robin arbiter sharing one IPbus DPRAM write port and PC handshake pair
// between dataChannels; a grant ends on a full four-phase handshake or a timeout.
module dump_arbiter #(
  parameter int          CHW     = 2,
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic          SYSCLK,
  input  logic          RESET,
  dump_arbiter_if.slave bus
);
  localparam int NCH = 2**CHW;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] GRANT     = 3'd1;
  localparam logic [2:0] WAITPC    = 3'd2;
  localparam logic [2:0] WAITREL   = 3'd3;
  localparam logic [2:0] WAITPCLOW = 3'd4;
  localparam logic [2:0] RELEASE   = 3'd5;

  logic [2:0]     state_reg,  state_next;
  logic [NCH-1:0] grant_reg,  grant_next;
  logic [CHW-1:0] active_reg, active_next;
  logic [CHW-1:0] ptr_reg,    ptr_next;
  logic [15:0]    timer_reg,  timer_next;
  logic [15:0]    tcount_reg, tcount_next;

  logic [31:0]    ram_data_reg;
  logic [7:0]     ram_addr_reg;
  logic           ram_we_reg;
  logic           hs_fpga_reg;

  logic [31:0]    ch_data [NCH];
  logic [7:0]     ch_addr [NCH];

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      assign ch_data[gi] = bus.ch_ram_data[32*gi +: 32];
      assign ch_addr[gi] = bus.ch_ram_address[8*gi +: 8];
    end
  endgenerate

  // Round-robin pick: first requester at ptr+1, ptr+2, ... (wrapping). The loop
  // runs from the farthest offset down so the nearest requester is kept last.
  logic           win_found;
  logic [CHW-1:0] win_idx;
  logic [CHW-1:0] cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_reg;
    cand      = ptr_reg;
    for (int k = NCH; k >= 1; k--) begin
      cand = ptr_reg + CHW'(k);
      if (bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  logic sel_req;
  logic sel_hs;
  logic in_timed;
  logic timer_hit;

  assign sel_req  = bus.req[active_reg];
  assign sel_hs   = bus.ch_handshakeFPGA[active_reg];
  assign in_timed = (state_reg == GRANT)   || (state_reg == WAITPC) ||
                    (state_reg == WAITREL) || (state_reg == WAITPCLOW);
  // The counter starts at 0 on entry, so a state is left after TIMEOUT cycles.
  assign timer_hit = in_timed && (timer_reg == TIMEOUT - 16'd1);

  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    active_next = active_reg;
    ptr_next    = ptr_reg;
    tcount_next = tcount_reg;
    timer_next  = '0;

    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next  = GRANT;
          grant_next  = NCH'(1) << win_idx;
          active_next = win_idx;
        end
      end
      GRANT: begin
        if (!sel_req) begin
          state_next = RELEASE;
        end else if (sel_hs) begin
          state_next = WAITPC;
        end
      end
      WAITPC: begin
        if (bus.handshakePC) begin
          state_next = WAITREL;
        end
      end
      WAITREL: begin
        if (!sel_hs) begin
          state_next = WAITPCLOW;
        end
      end
      WAITPCLOW: begin
        if (!bus.handshakePC) begin
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        state_next = IDLE;
        ptr_next   = active_reg;
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase

    // Timeout overrides whatever the handshake would have done this cycle.
    if (timer_hit) begin
      state_next = RELEASE;
      if (tcount_reg != 16'hFFFF) begin
        tcount_next = tcount_reg + 16'd1;
      end
    end

    if (state_next == RELEASE) begin
      grant_next = '0;
    end

    if (state_reg != IDLE && state_next == state_reg) begin
      timer_next = timer_reg + 16'd1;
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      active_reg <= '0;
      ptr_reg    <= {CHW{1'b1}};
      timer_reg  <= '0;
      tcount_reg <= '0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      active_reg <= active_next;
      ptr_reg    <= ptr_next;
      timer_reg  <= timer_next;
      tcount_reg <= tcount_next;
    end
  end

  // Data, address and write enable share one register stage to stay aligned.
  always_ff @(posedge SYSCLK) begin
    if (RESET || grant_reg == '0) begin
      ram_data_reg <= '0;
      ram_addr_reg <= '0;
      ram_we_reg   <= 1'b0;
      hs_fpga_reg  <= 1'b0;
    end else begin
      ram_data_reg <= ch_data[active_reg];
      ram_addr_reg <= ch_addr[active_reg];
      ram_we_reg   <= bus.ch_ram_we[active_reg];
      hs_fpga_reg  <= sel_hs;
    end
  end

  assign bus.grant             = grant_reg;
  assign bus.ch_handshakePC    = {NCH{bus.handshakePC}} & grant_reg;
  assign bus.IPbus_RAM_data    = ram_data_reg;
  assign bus.IPbus_RAM_address = ram_addr_reg;
  assign bus.IPbus_RAM_we      = ram_we_reg;
  assign bus.handshakeFPGA     = hs_fpga_reg;
  assign bus.active_ch         = active_reg;
  assign bus.busy              = (state_reg != IDLE);
  assign bus.timeout_count     = tcount_reg;
endmodule

// File: tb/tb_dump_arbiter.sv
// Randomized episodes of channel dumps (handshake, withdrawal, timeout) checked by a
// scoreboard monitor against a round-robin reference model.
`timescale 1ns/1ps
module tb_dump_arbiter;
  localparam int          CHW  = 2;
  localparam int          NCH  = 4;
  localparam logic [15:0] TMO  = 16'd16;
  localparam int          N_EP = 120;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dump_arbiter_if #(.CHW(CHW)) bus();

  dump_arbiter #(.CHW(CHW), .TIMEOUT(TMO)) dut (
    .SYSCLK (clk),
    .RESET  (rst),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int          exp_grant_q[$];
  logic [15:0] exp_tc_q[$];
  logic [39:0] exp_wr_q[$];

  // reference model state
  int             owner      = -1;
  int             exp_act    = 0;
  logic           exp_busy   = 1'b0;
  logic [15:0]    exp_tc     = 16'd0;
  int             last_model = NCH - 1;
  logic [NCH-1:0] pend       = '0;
  logic           own_hs     = 1'b0;
  logic           pc_int     = 1'b0;
  logic           mon_on     = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NCH-1:0] oh(input int c);
    logic [NCH-1:0] r;
    r = '0;
    if (c >= 0) r[c] = 1'b1;
    return r;
  endfunction

  // Next requester after the last winner, wrapping around the channel count.
  function automatic int rr_pick(input logic [NCH-1:0] p, input int last);
    int c;
    for (int k = 1; k <= NCH; k++) begin
      c = (last + k) % NCH;
      if (p[c]) return c;
    end
    return -1;
  endfunction

  // Drive one cycle: owner gets intended values, everything else is random noise.
  task automatic cycle();
    logic [NCH-1:0] hs_v;
    logic [NCH-1:0] we_v;
    hs_v = NCH'($urandom());
    we_v = NCH'($urandom());
    for (int i = 0; i < NCH; i++) begin
      bus.ch_ram_data[32*i +: 32]   = $urandom();
      bus.ch_ram_address[8*i +: 8]  = 8'($urandom());
    end
    if (owner >= 0) hs_v[owner] = own_hs;
    bus.ch_handshakeFPGA = hs_v;
    bus.ch_ram_we        = we_v;
    bus.req              = pend;
    bus.handshakePC      = (owner >= 0) ? pc_int : 1'($urandom());
    if (owner >= 0 && we_v[owner] && !rst)
      exp_wr_q.push_back({bus.ch_ram_address[8*owner +: 8], bus.ch_ram_data[32*owner +: 32]});
    @(posedge clk);
    #1;
  endtask

  task automatic apply_exit(input int ph);
    case (ph)
      0: own_hs = 1'b1;
      1: pc_int = 1'b1;
      2: own_hs = 1'b0;
      default: pc_int = 1'b0;
    endcase
  endtask

  // kind: 0/1 full handshake, 2 request withdrawal, 3 timeout in a random phase
  task automatic episode(input int kind);
    int   w;
    int   stall;
    logic tmo;
    w = rr_pick(pend, last_model);
    exp_grant_q.push_back(w);
    own_hs = 1'b0;
    pc_int = 1'b0;
    cycle();
    owner      = w;
    exp_act    = w;
    exp_busy   = 1'b1;
    last_model = w;
    if ($urandom_range(0, 2) == 0) pend |= NCH'($urandom());
    tmo = 1'b0;
    if (kind == 2) begin
      repeat ($urandom_range(0, 3)) cycle();
      pend[w] = 1'b0;
      cycle();
    end else begin
      stall = (kind == 3) ? int'($urandom_range(0, 3)) : 4;
      for (int ph = 0; ph < 4 && !tmo; ph++) begin
        if (ph == stall) begin
          repeat (int'(TMO) - 1) cycle();
          if ($urandom_range(0, 1) == 1) apply_exit(ph);
          cycle();
          tmo = 1'b1;
        end else begin
          repeat ($urandom_range(0, 3)) cycle();
          apply_exit(ph);
          cycle();
        end
      end
    end
    if (tmo && exp_tc != 16'hFFFF) exp_tc = exp_tc + 16'd1;
    exp_tc_q.push_back(exp_tc);
    owner   = -1;
    pend[w] = 1'b0;
    own_hs  = 1'b0;
    pc_int  = 1'b0;
    if ($urandom_range(0, 3) == 0) pend |= NCH'($urandom());
    cycle();
    exp_busy = 1'b0;
  endtask

  // Monitor: per-cycle routing checks plus scoreboard pops on grant/write events.
  logic [NCH-1:0] prev_grant = '0;
  logic           nxt_hsf    = 1'b0;
  logic           nxt_zero   = 1'b1;

  always @(negedge clk) begin
    logic [NCH-1:0] eg;
    int             wq;
    logic [15:0]    tq;
    logic [39:0]    xq;
    if (mon_on) begin
      eg = oh(owner);
      check("grant", 64'(bus.grant), 64'(eg));
      check("active_ch", 64'(bus.active_ch), 64'(exp_act));
      check("busy", 64'(bus.busy), 64'(exp_busy));
      check("ch_handshakePC", 64'(bus.ch_handshakePC), 64'(bus.handshakePC ? eg : '0));
      check("handshakeFPGA", 64'(bus.handshakeFPGA), 64'(nxt_hsf));
      if (nxt_zero)
        check("ipbus_idle", 64'({bus.IPbus_RAM_we, bus.IPbus_RAM_address, bus.IPbus_RAM_data}), 64'd0);
      if (prev_grant == '0 && bus.grant != '0) begin
        if (exp_grant_q.size() == 0) begin
          check("grant_unexpected", 64'(bus.grant), 64'd0);
        end else begin
          wq = exp_grant_q.pop_front();
          check("grant_order", 64'(bus.grant), 64'(oh(wq)));
        end
      end
      if (prev_grant != '0 && bus.grant == '0) begin
        if (exp_tc_q.size() == 0) begin
          check("release_unexpected", 64'(prev_grant), 64'd0);
        end else begin
          tq = exp_tc_q.pop_front();
          check("timeout_count", 64'(bus.timeout_count), 64'(tq));
        end
      end
      if (bus.IPbus_RAM_we) begin
        if (exp_wr_q.size() == 0) begin
          check("write_unexpected", 64'(bus.IPbus_RAM_we), 64'd0);
        end else begin
          xq = exp_wr_q.pop_front();
          check("ram_write", 64'({bus.IPbus_RAM_address, bus.IPbus_RAM_data}), 64'(xq));
        end
      end
      prev_grant = bus.grant;
      nxt_hsf    = (owner >= 0 && !rst) ? bus.ch_handshakeFPGA[owner] : 1'b0;
      nxt_zero   = !(owner >= 0 && !rst);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bus.req              = '0;
    bus.ch_ram_data      = '0;
    bus.ch_ram_address   = '0;
    bus.ch_ram_we        = '0;
    bus.ch_handshakeFPGA = '0;
    bus.handshakePC      = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_grant", 64'(bus.grant), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_active_ch", 64'(bus.active_ch), 64'd0);
    check("rst_timeout_count", 64'(bus.timeout_count), 64'd0);
    check("rst_ipbus", 64'({bus.IPbus_RAM_we, bus.handshakeFPGA, bus.IPbus_RAM_address, bus.IPbus_RAM_data}), 64'd0);
    mon_on = 1'b1;

    // all channels requesting: strict rotation 0,1,2,3,0
    for (int e = 0; e < 5; e++) begin
      pend = 4'hF;
      episode(0);
    end

    for (int e = 0; e < N_EP; e++) begin
      if (pend == '0) begin
        repeat ($urandom_range(0, 2)) cycle();
        pend = NCH'($urandom_range(1, 2**NCH - 1));
      end
      episode(int'($urandom_range(0, 3)));
    end

    // drain, then reset in the middle of a transaction (WAITPC)
    while (pend != '0) episode(0);
    pend = 4'b0100;
    w = rr_pick(pend, last_model);
    exp_grant_q.push_back(w);
    own_hs = 1'b0;
    pc_int = 1'b0;
    cycle();
    owner      = w;
    exp_act    = w;
    exp_busy   = 1'b1;
    last_model = w;
    own_hs = 1'b1;
    cycle();
    rst = 1'b1;
    exp_tc_q.push_back(16'd0);
    cycle();
    rst        = 1'b0;
    owner      = -1;
    exp_busy   = 1'b0;
    exp_act    = 0;
    exp_tc     = 16'd0;
    last_model = NCH - 1;
    own_hs     = 1'b0;
    check("midrst_grant", 64'(bus.grant), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_timeout_count", 64'(bus.timeout_count), 64'd0);
    check("midrst_ipbus", 64'({bus.IPbus_RAM_we, bus.handshakeFPGA, bus.IPbus_RAM_address, bus.IPbus_RAM_data}), 64'd0);
    pend = 4'hF;
    episode(0);
    pend = '0;
    repeat (3) cycle();

    check("grant_q_left", 64'(exp_grant_q.size()), 64'd0);
    check("tc_q_left", 64'(exp_tc_q.size()), 64'd0);
    check("wr_q_left", 64'(exp_wr_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
